// File: rtl/pixel_rom_arbiter_pkg.sv
// rtl/pixel_rom_arbiter_pkg.sv - shared sizes and requester ids for the pixel ROM arbiter
package pixel_rom_pkg;
    localparam int NREQ    = 3;
    localparam int X_SZ    = 8;
    localparam int Y_SZ    = 7;
    localparam int ADDR_SZ = 15;
    localparam int COL_SZ  = 3;
    localparam int X_RES   = 60;
    localparam int Y_RES   = 60;

    localparam int REQ_SCAN = 0;
    localparam int REQ_TB   = 1;
    localparam int REQ_LR   = 2;

    localparam logic [COL_SZ-1:0] BLACK_THRESHOLD = '0;
endpackage

// File: rtl/pixel_rom_arbiter_if.sv
// rtl/pixel_rom_arbiter_if.sv - requester and ROM signal bundle of the pixel ROM arbiter
interface pixel_rom_arbiter_if
    import pixel_rom_pkg::*;
#(
    parameter int N = NREQ
);
    logic [N-1:0]      req;
    logic [N*X_SZ-1:0] req_x;
    logic [N*Y_SZ-1:0] req_y;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rsp_valid;
    logic [COL_SZ-1:0] rsp_pix;
    logic              rsp_oob;
    logic [ADDR_SZ-1:0] rom_addr;
    logic [COL_SZ-1:0] rom_q;
    logic              busy;

    modport slave (
        input  req, req_x, req_y, rom_q,
        output gnt, rsp_valid, rsp_pix, rsp_oob, rom_addr, busy
    );

    modport master (
        output req, req_x, req_y, rom_q,
        input  gnt, rsp_valid, rsp_pix, rsp_oob, rom_addr, busy
    );
endinterface

// File: rtl/pixel_rom_arbiter_rr_pick.sv
// rtl/pixel_rom_arbiter_rr_pick.sv - round-robin pick: first asserted request at or after rrPtr
module rr_pick #(
    parameter int NREQ  = 3,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] rrPtr,
    output logic [NREQ-1:0]  gnt,
    output logic [PTR_W-1:0] idx
);
    logic found;
    int   cand;

    // Walking offsets from rrPtr is the rotate/find/unrotate folded into one loop.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < NREQ; off++) begin
            cand = int'(rrPtr) + off;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = PTR_W'(cand);
            end
        end
    end
endmodule

// File: rtl/pixel_rom_arbiter.sv
// rtl/pixel_rom_arbiter.sv - round-robin share of one image ROM among the star finders
module pixel_rom_arbiter
    import pixel_rom_pkg::*;
#(
    parameter int N = NREQ
) (
    input logic clk,
    input logic resetn,
    pixel_rom_arbiter_if.slave bus
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int AW    = ADDR_SZ + 1;

    logic [PTR_W-1:0]  rrPtr;
    logic [N-1:0]      pickGnt;
    logic [PTR_W-1:0]  pickIdx;
    logic              anyGnt;
    logic [X_SZ-1:0]   selX;
    logic [Y_SZ-1:0]   selY;
    logic              selOob;
    logic [AW-1:0]     addrWide;

    logic [N-1:0]      gntQ;
    logic              oobQ;
    logic              validQ;
    logic [COL_SZ-1:0] pixHold;

    rr_pick #(.NREQ(N), .PTR_W(PTR_W)) u_pick (
        .req   (bus.req),
        .rrPtr (rrPtr),
        .gnt   (pickGnt),
        .idx   (pickIdx)
    );

    // Grant and address are combinational, so reset has to mask them explicitly.
    assign anyGnt  = resetn && (pickGnt != '0);
    assign bus.gnt = resetn ? pickGnt : '0;

    always_comb begin
        selX = '0;
        selY = '0;
        for (int i = 0; i < N; i++) begin
            if (pickGnt[i]) begin
                selX = bus.req_x[i*X_SZ +: X_SZ];
                selY = bus.req_y[i*Y_SZ +: Y_SZ];
            end
        end
    end

    assign selOob   = (int'(selX) >= X_RES) || (int'(selY) >= Y_RES);
    assign addrWide = AW'(selY) * AW'(X_RES) + AW'(selX);

    // Out-of-range coordinates still take the slot but read a harmless address 0.
    assign bus.rom_addr = (anyGnt && !selOob) ? addrWide[ADDR_SZ-1:0] : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rrPtr   <= '0;
            gntQ    <= '0;
            oobQ    <= 1'b0;
            validQ  <= 1'b0;
            pixHold <= '0;
        end else begin
            gntQ    <= anyGnt ? pickGnt : '0;
            validQ  <= anyGnt;
            pixHold <= bus.rsp_pix;
            if (anyGnt) begin
                oobQ  <= selOob;
                rrPtr <= (pickIdx == PTR_W'(N - 1)) ? '0 : pickIdx + PTR_W'(1);
            end
        end
    end

    // rom_q is the ROM's own output register, so the pixel lands in the response cycle.
    assign bus.rsp_pix   = validQ ? (oobQ ? '0 : bus.rom_q) : pixHold;
    assign bus.rsp_valid = gntQ;
    assign bus.rsp_oob   = oobQ;
    assign bus.busy      = validQ;
endmodule

// File: tb/tb_pixel_rom_arbiter.sv
// tb/tb_pixel_rom_arbiter.sv - directed and random checks of pixel_rom_arbiter against a reference model
module tb_pixel_rom_arbiter;
    logic clk = 1'b0;
    logic resetn;

    pixel_rom_arbiter_if #(.N(3)) bus ();

    pixel_rom_arbiter #(.N(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ROM: each word holds the low three address bits.
    always @(posedge clk) bus.rom_q <= bus.rom_addr[2:0];

    int checks = 0;
    int errors = 0;

    int   ptr = 0;
    int   expRv = 0;
    int   expPix = 0;
    int   expOob = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] r, input logic [23:0] xs, input logic [20:0] ys);
        int k, c, x, y, a;
        bit o;
        bus.req   = r;
        bus.req_x = xs;
        bus.req_y = ys;
        k = -1;
        for (int off = 0; off < 3; off++) begin
            c = (ptr + off) % 3;
            if (k < 0 && r[c]) k = c;
        end
        a = 0;
        o = 0;
        if (k >= 0) begin
            x = int'(xs[k*8 +: 8]);
            y = int'(ys[k*7 +: 7]);
            o = (x >= 60) || (y >= 60);
            a = o ? 0 : (y * 60 + x) % 32768;
        end
        @(negedge clk);
        chk("gnt", 32'(bus.gnt), (k >= 0) ? (1 << k) : 0);
        chk("rom_addr", 32'(bus.rom_addr), a);
        chk("rsp_valid", 32'(bus.rsp_valid), expRv);
        chk("rsp_pix", 32'(bus.rsp_pix), expPix);
        chk("rsp_oob", 32'(bus.rsp_oob), expOob);
        chk("busy", 32'(bus.busy), (expRv != 0) ? 1 : 0);
        if (k >= 0) begin
            ptr    = (k + 1) % 3;
            expRv  = 1 << k;
            expPix = o ? 0 : a % 8;
            expOob = o ? 1 : 0;
        end else begin
            expRv = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stepAll(input logic [2:0] r, input int x, input int y);
        logic [7:0] xb;
        logic [6:0] yb;
        xb = 8'(x);
        yb = 7'(y);
        step(r, {xb, xb, xb}, {yb, yb, yb});
    endtask

    initial begin
        logic [23:0] rx;
        logic [20:0] ry;

        resetn    = 1'b0;
        bus.req   = 3'b111;
        bus.req_x = '0;
        bus.req_y = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", 32'(bus.gnt), 0);
        chk("reset_rom_addr", 32'(bus.rom_addr), 0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("reset_rsp_pix", 32'(bus.rsp_pix), 0);
        chk("reset_rsp_oob", 32'(bus.rsp_oob), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        bus.req = 3'b000;
        resetn  = 1'b1;
        @(posedge clk);
        #1;

        // single request from the top/bottom finder
        stepAll(3'b010, 5, 2);
        stepAll(3'b000, 0, 0);

        // re-reset so contention starts at pointer 0
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        ptr = 0; expRv = 0; expPix = 0; expOob = 0;
        @(posedge clk);
        #1;
        repeat (6) stepAll(3'b111, 5, 2);

        // pointer skip
        stepAll(3'b001, 1, 1);
        stepAll(3'b101, 3, 4);
        stepAll(3'b101, 7, 4);

        // out of range and far corner
        stepAll(3'b001, 60, 10);
        stepAll(3'b001, 10, 60);
        stepAll(3'b001, 59, 59);
        stepAll(3'b000, 0, 0);

        // back-to-back single requester
        for (int x = 0; x < 10; x++) stepAll(3'b010, x, 0);
        stepAll(3'b000, 0, 0);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            for (int s = 0; s < 3; s++) begin
                rx[s*8 +: 8] = 8'($urandom_range(0, 70));
                ry[s*7 +: 7] = 7'($urandom_range(0, 66));
            end
            step(3'($urandom_range(0, 7)), rx, ry);
        end

        // reset while a grant to requester 2 is in flight
        stepAll(3'b001, 2, 2);
        bus.req = 3'b100;
        @(negedge clk);
        chk("midreset_gnt", 32'(bus.gnt), 4);
        #2;
        resetn = 1'b0;
        #1;
        chk("midreset_gnt_masked", 32'(bus.gnt), 0);
        chk("midreset_rsp_valid", 32'(bus.rsp_valid), 0);
        @(posedge clk);
        #1;
        chk("midreset_rsp_valid_n1", 32'(bus.rsp_valid), 0);
        chk("midreset_busy_n1", 32'(bus.busy), 0);
        @(negedge clk);
        bus.req = 3'b000;
        resetn  = 1'b1;
        ptr = 0; expRv = 0; expPix = 0; expOob = 0;
        @(posedge clk);
        #1;
        stepAll(3'b000, 0, 0);
        stepAll(3'b111, 4, 4);
        stepAll(3'b000, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
